// File: rtl/datamem_ctrl.sv
// Burst controller for an X/Y-addressed data memory.
// Accepts 1-4 beat read or write bursts, splits the address into row (X)
// and column (Y) halves, and returns read beats plus a single write ack
// on a valid/ready response channel.
module datamem_ctrl #(
  parameter int unsigned ADDR_BITS  = 8,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                    Clock,
  input  logic                    Reset_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_BITS-1:0]    req_addr,
  input  logic [1:0]              req_len,
  input  logic                    wdata_valid,
  output logic                    wdata_ready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  output logic                    rsp_last,
  output logic                    mem_we,
  output logic [ADDR_BITS/2-1:0]  mem_x,
  output logic [ADDR_BITS/2-1:0]  mem_y,
  output logic [DATA_WIDTH-1:0]   mem_din,
  input  logic [DATA_WIDTH-1:0]   mem_dout
);

  localparam int unsigned HALF = ADDR_BITS / 2;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    WR_ACK,
    RD_ADDR,
    RD_CAP,
    RD_RSP
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_BITS-1:0]    cur_addr_q, cur_addr_d;
  logic [1:0]              beats_left_q, beats_left_d;
  logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;

  // State and datapath registers; reset abandons any burst in flight.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= IDLE;
      cur_addr_q   <= '0;
      beats_left_q <= '0;
      rsp_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      beats_left_q <= beats_left_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  // Next-state, datapath updates and handshake outputs.
  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    beats_left_d = beats_left_q;
    rsp_data_d   = rsp_data_q;
    req_ready    = 1'b0;
    wdata_ready  = 1'b0;
    mem_we       = 1'b0;
    rsp_valid    = 1'b0;
    rsp_last     = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          cur_addr_d   = req_addr;
          beats_left_d = req_len;
          state_d      = req_write ? WRITE : RD_ADDR;
        end
      end
      WRITE: begin
        wdata_ready = 1'b1;
        mem_we      = wdata_valid;
        if (wdata_valid) begin
          cur_addr_d   = cur_addr_q + ADDR_BITS'(1);
          beats_left_d = beats_left_q - 2'd1;
          if (beats_left_q == 2'd0) state_d = WR_ACK;
        end
      end
      WR_ACK: begin
        rsp_valid = 1'b1;
        rsp_last  = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      RD_ADDR: begin
        state_d = RD_CAP;
      end
      RD_CAP: begin
        // Memory output reflects the address driven during RD_ADDR.
        rsp_data_d = mem_dout;
        state_d    = RD_RSP;
      end
      RD_RSP: begin
        rsp_valid = 1'b1;
        rsp_last  = (beats_left_q == 2'd0);
        if (rsp_ready) begin
          if (beats_left_q == 2'd0) begin
            state_d = IDLE;
          end else begin
            cur_addr_d   = cur_addr_q + ADDR_BITS'(1);
            beats_left_d = beats_left_q - 2'd1;
            state_d      = RD_ADDR;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_x    = cur_addr_q[ADDR_BITS-1:HALF];
  assign mem_y    = cur_addr_q[HALF-1:0];
  assign mem_din  = wdata;
  assign rsp_data = rsp_data_q;

endmodule

// File: tb/tb_datamem_ctrl.sv
// Scoreboard bench for datamem_ctrl with a behavioural X/Y memory.
module tb_datamem_ctrl;

  logic       Clock;
  logic       Reset_n;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [7:0] req_addr;
  logic [1:0] req_len;
  logic       wdata_valid;
  logic       wdata_ready;
  logic [7:0] wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_last;
  logic       mem_we;
  logic [3:0] mem_x;
  logic [3:0] mem_y;
  logic [7:0] mem_din;
  logic [7:0] mem_dout;

  datamem_ctrl #(.ADDR_BITS(8), .DATA_WIDTH(8)) dut (
    .Clock       (Clock),
    .Reset_n     (Reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_len     (req_len),
    .wdata_valid (wdata_valid),
    .wdata_ready (wdata_ready),
    .wdata       (wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_last    (rsp_last),
    .mem_we      (mem_we),
    .mem_x       (mem_x),
    .mem_y       (mem_y),
    .mem_din     (mem_din),
    .mem_dout    (mem_dout)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Behavioural memory: registered read, one clock after the address.
  logic [7:0] mem [256];
  initial for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  always @(posedge Clock) begin
    if (mem_we) mem[{mem_x, mem_y}] <= mem_din;
    mem_dout <= mem[{mem_x, mem_y}];
  end

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } rsp_t;

  rsp_t        rq[$];
  logic [15:0] wq[$];
  int          pass_cnt = 0;
  int          tot_cnt  = 0;
  logic [7:0]  last_rd  = 8'h00;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
  endtask

  // Monitor: pops expectations whenever the DUT presents a response or a write.
  always @(negedge Clock) begin
    if (Reset_n && rsp_valid && rsp_ready) begin
      if (rq.size() == 0) chk("rsp_unexpected", 1, 0);
      else begin
        rsp_t e;
        e = rq.pop_front();
        chk("rsp_data", {24'h0, rsp_data}, {24'h0, e.data});
        chk("rsp_last", {31'h0, rsp_last}, {31'h0, e.last});
      end
    end
    if (mem_we) begin
      if (wq.size() == 0) chk("we_unexpected", 1, 0);
      else begin
        logic [15:0] w;
        w = wq.pop_front();
        chk("mem_wr_addr", {24'h0, mem_x, mem_y}, {24'h0, w[15:8]});
        chk("mem_wr_data", {24'h0, mem_din}, {24'h0, w[7:0]});
      end
    end
  end

  task automatic issue_req(input logic wr, input logic [7:0] addr, input logic [1:0] len);
    int n;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_len   = len;
    n = 0;
    do begin @(negedge Clock); n++; end while (!req_ready && n < 20);
    if (!req_ready) chk("req_timeout", 0, 1);
    @(posedge Clock); #1;
    req_valid = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] addr, input logic [1:0] len,
                          input logic [31:0] d, input int stall_at, input int rst_at);
    int n;
    logic [7:0] a;
    logic [7:0] v;
    issue_req(1'b1, addr, len);
    for (int b = 0; b <= int'(len); b++) begin
      a = addr + 8'(b);
      v = d[8*b +: 8];
      if (b == stall_at) begin
        wdata_valid = 1'b0;
        repeat (4) begin
          @(negedge Clock);
          chk("stall_we", {31'h0, mem_we}, 0);
          chk("stall_addr", {24'h0, mem_x, mem_y}, {24'h0, a});
          @(posedge Clock); #1;
        end
      end
      if (b == rst_at) begin
        wdata_valid = 1'b1;
        wdata       = v;
        #1;
        chk("we_before_rst", {31'h0, mem_we}, 1);
        Reset_n = 1'b0;
        #1;
        chk("rst_we", {31'h0, mem_we}, 0);
        chk("rst_wdata_ready", {31'h0, wdata_ready}, 0);
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 0);
        chk("rst_rsp_last", {31'h0, rsp_last}, 0);
        chk("rst_rsp_data", {24'h0, rsp_data}, 0);
        chk("rst_addr", {24'h0, mem_x, mem_y}, 0);
        repeat (2) @(posedge Clock);
        #1;
        Reset_n     = 1'b1;
        wdata_valid = 1'b0;
        @(negedge Clock);
        chk("rst_req_ready", {31'h0, req_ready}, 1);
        @(posedge Clock); #1;
        last_rd = 8'h00;
        return;
      end
      wq.push_back({a, v});
      wdata_valid = 1'b1;
      wdata       = v;
      n = 0;
      do begin @(negedge Clock); n++; end while (!wdata_ready && n < 20);
      if (!wdata_ready) chk("wdata_timeout", 0, 1);
      @(posedge Clock); #1;
    end
    wdata_valid = 1'b0;
    rq.push_back('{data: last_rd, last: 1'b1});
    n = 0;
    do begin @(negedge Clock); n++; end while (!rsp_valid && n < 20);
    chk("wr_ack_latency", n, 1);
    @(posedge Clock); #1;
    @(negedge Clock);
    chk("wr_idle_ready", {31'h0, req_ready}, 1);
    @(posedge Clock); #1;
  endtask

  task automatic do_read(input logic [7:0] addr, input logic [1:0] len,
                         input logic [31:0] d, input int bp_at);
    int n;
    logic [7:0] v;
    issue_req(1'b0, addr, len);
    for (int b = 0; b <= int'(len); b++) begin
      if (b > 0) begin @(posedge Clock); #1; end
      v = d[8*b +: 8];
      rq.push_back('{data: v, last: (b == int'(len))});
      if (b == bp_at) rsp_ready = 1'b0;
      n = 0;
      do begin @(negedge Clock); n++; end while (!rsp_valid && n < 20);
      chk("rd_latency", n, 3);
      if (b == bp_at) begin
        repeat (4) begin
          @(negedge Clock);
          chk("bp_valid", {31'h0, rsp_valid}, 1);
          chk("bp_data", {24'h0, rsp_data}, {24'h0, v});
          chk("bp_we", {31'h0, mem_we}, 0);
        end
        @(posedge Clock); #1;
        rsp_ready = 1'b1;
        @(negedge Clock);
      end
      if (b == int'(len)) begin
        chk("last_hs_req_ready", {31'h0, req_ready}, 0);
        @(negedge Clock);
        chk("post_rd_req_ready", {31'h0, req_ready}, 1);
        chk("post_rd_rsp_valid", {31'h0, rsp_valid}, 0);
      end
    end
    last_rd = d[8*int'(len) +: 8];
    @(posedge Clock); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    Reset_n     = 1'b0;
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_addr    = 8'h00;
    req_len     = 2'd0;
    wdata_valid = 1'b0;
    wdata       = 8'h00;
    rsp_ready   = 1'b1;
    repeat (2) @(negedge Clock);
    chk("reset_rsp_valid", {31'h0, rsp_valid}, 0);
    chk("reset_wdata_ready", {31'h0, wdata_ready}, 0);
    chk("reset_mem_we", {31'h0, mem_we}, 0);
    chk("reset_rsp_data", {24'h0, rsp_data}, 0);
    chk("reset_addr", {24'h0, mem_x, mem_y}, 0);
    @(posedge Clock); #1;
    Reset_n = 1'b1;
    @(negedge Clock);
    chk("reset_req_ready", {31'h0, req_ready}, 1);
    @(posedge Clock); #1;

    // Single write then read back.
    do_write(8'h3A, 2'd0, 32'h0000005C, -1, -1);
    do_read (8'h3A, 2'd0, 32'h0000005C, -1);
    // Wrapping 4-beat burst, read back with backpressure on beat 2.
    do_write(8'hFE, 2'd3, 32'h04030201, -1, -1);
    do_read (8'hFE, 2'd3, 32'h04030201, 1);
    // Write data stall between beats.
    do_write(8'h10, 2'd2, 32'h00332211, 1, -1);
    do_read (8'h10, 2'd2, 32'h00332211, -1);
    // Reset after beat 2 of 4; beats 3 and 4 must stay unwritten.
    do_write(8'h40, 2'd3, 32'hA4A3A2A1, -1, 2);
    do_read (8'h40, 2'd3, 32'h0000A2A1, -1);

    repeat (4) @(negedge Clock);
    chk("rsp_queue_drained", rq.size(), 0);
    chk("wr_queue_drained", wq.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
